// File: rtl/ibex_pkg.sv
// Shared constants and types for the interrupt arbiter: cause codes, FSM state
// encoding and the captured-selection record.
package ibex_pkg;

   localparam logic [5:0] EXC_CAUSE_IRQ_SOFTWARE_M = 6'h23;
   localparam logic [5:0] EXC_CAUSE_IRQ_TIMER_M    = 6'h27;
   localparam logic [5:0] EXC_CAUSE_IRQ_EXTERNAL_M = 6'h2B;
   localparam logic [5:0] EXC_CAUSE_IRQ_NM         = 6'h3F;

   typedef enum logic [1:0] {
      IRQ_ARB_IDLE = 2'd0,
      IRQ_ARB_REQ  = 2'd1,
      IRQ_ARB_HOLD = 2'd2
   } irq_arb_state_e;

   typedef struct packed {
      logic [5:0] cause;
      logic       is_nm;
   } irq_sel_t;

   // Fast interrupt causes sit in the 0x30..0x3E window, indexed by source id.
   function automatic logic [5:0] irq_fast_cause(input logic [3:0] id);
      return {2'b11, id};
   endfunction

endpackage

// File: rtl/ibex_irq_prio_enc.sv
// Combinational priority encoder: picks the highest-priority eligible interrupt
// and returns its cause code and NMI flag.
module ibex_irq_prio_enc
   import ibex_pkg::*;
(
   input  logic        nm,
   input  logic [14:0] fast,
   input  logic        external,
   input  logic        software,
   input  logic        timer,
   output logic        valid,
   output logic [5:0]  cause,
   output logic        is_nm
);

   // Evaluated lowest priority first so each later hit overrides the earlier ones.
   always_comb begin
      valid = 1'b0;
      cause = '0;
      is_nm = 1'b0;
      if (timer) begin
         valid = 1'b1;
         cause = EXC_CAUSE_IRQ_TIMER_M;
      end
      if (software) begin
         valid = 1'b1;
         cause = EXC_CAUSE_IRQ_SOFTWARE_M;
      end
      if (external) begin
         valid = 1'b1;
         cause = EXC_CAUSE_IRQ_EXTERNAL_M;
      end
      for (int i = 0; i < 15; i++) begin
         if (fast[i]) begin
            valid = 1'b1;
            cause = irq_fast_cause(4'(i));
         end
      end
      if (nm) begin
         valid = 1'b1;
         cause = EXC_CAUSE_IRQ_NM;
         is_nm = 1'b1;
      end
   end

endmodule

// File: rtl/ibex_irq_arbiter.sv
// Interrupt arbiter: registers sources, masks them, and hands one frozen request
// at a time to the controller. Define IBEX_IRQ_FAST_EDGE_EN for edge-triggered fast sources.
module ibex_irq_arbiter
   import ibex_pkg::*;
#(
   parameter int unsigned HOLDOFF_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        irq_software_i,
   input  logic        irq_timer_i,
   input  logic        irq_external_i,
   input  logic [14:0] irq_fast_i,
   input  logic        irq_nm_i,
   input  logic        mie_msie_i,
   input  logic        mie_mtie_i,
   input  logic        mie_meie_i,
   input  logic [14:0] mie_fast_i,
   input  logic        csr_mstatus_mie_i,
   input  logic        debug_mode_i,
   input  logic        irq_ack_i,
   input  logic        nmi_done_i,
   output logic        irq_req_o,
   output logic [5:0]  irq_cause_o,
   output logic        irq_is_nm_o,
   output logic        mip_msip_o,
   output logic        mip_mtip_o,
   output logic        mip_meip_o,
   output logic [14:0] mip_fast_o,
   output logic        nmi_active_o
);

   irq_arb_state_e state_q, state_d;
   irq_sel_t       sel_q, sel_d;
   logic [3:0]     cnt_q, cnt_d;

   logic        sw_q, tmr_q, ext_q, nm_q, nm_prev_q;
   logic [14:0] fast_q, fast_ip;
   logic        nm_pend_q, nmi_active_q;

   logic        gate, nm_elig, sw_elig, tmr_elig, ext_elig;
   logic [14:0] fast_elig;
   logic [15:0] fast_elig_ext;
   logic        captured_elig, ack_take, nm_ack, nm_edge;
   logic        enc_valid, enc_is_nm;
   logic [5:0]  enc_cause;

   assign nm_edge  = nm_q & ~nm_prev_q;
   assign ack_take = (state_q == IRQ_ARB_REQ) & irq_ack_i;
   assign nm_ack   = ack_take & sel_q.is_nm;

`ifdef IBEX_IRQ_FAST_EDGE_EN
   logic [14:0] fast_prev_q, fast_pend_q, fast_clr;

   // Only an acknowledged fast request retires its sticky pending bit.
   assign fast_clr = (ack_take && !sel_q.is_nm && sel_q.cause[5:4] == 2'b11) ?
                     (15'(1) << sel_q.cause[3:0]) : '0;
   assign fast_ip  = fast_pend_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fast_prev_q <= '0;
         fast_pend_q <= '0;
      end else begin
         fast_prev_q <= fast_q;
         fast_pend_q <= (fast_pend_q & ~fast_clr) | (fast_q & ~fast_prev_q);
      end
   end
`else
   assign fast_ip = fast_q;
`endif

   assign gate      = csr_mstatus_mie_i & ~debug_mode_i & (cnt_q == 4'd0);
   assign sw_elig   = sw_q & mie_msie_i & gate;
   assign tmr_elig  = tmr_q & mie_mtie_i & gate;
   assign ext_elig  = ext_q & mie_meie_i & gate;
   assign fast_elig = fast_ip & mie_fast_i & {15{gate}};
   assign nm_elig   = nm_pend_q & ~nmi_active_q & ~debug_mode_i;
   assign fast_elig_ext = {1'b0, fast_elig};

   ibex_irq_prio_enc u_prio_enc (
      .nm       (nm_elig),
      .fast     (fast_elig),
      .external (ext_elig),
      .software (sw_elig),
      .timer    (tmr_elig),
      .valid    (enc_valid),
      .cause    (enc_cause),
      .is_nm    (enc_is_nm)
   );

   // Re-check the source frozen in sel_q so a dropped or masked request is withdrawn.
   always_comb begin
      captured_elig = 1'b0;
      if (sel_q.is_nm) begin
         captured_elig = nm_elig;
      end else begin
         case (sel_q.cause)
            EXC_CAUSE_IRQ_EXTERNAL_M: captured_elig = ext_elig;
            EXC_CAUSE_IRQ_SOFTWARE_M: captured_elig = sw_elig;
            EXC_CAUSE_IRQ_TIMER_M:    captured_elig = tmr_elig;
            default:                  captured_elig = fast_elig_ext[sel_q.cause[3:0]];
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      case (state_q)
         IRQ_ARB_IDLE: begin
            if (enc_valid) begin
               sel_d   = '{cause: enc_cause, is_nm: enc_is_nm};
               state_d = IRQ_ARB_REQ;
            end
         end
         IRQ_ARB_REQ: begin
            if (irq_ack_i) begin
               cnt_d   = 4'(HOLDOFF_CYCLES);
               state_d = (HOLDOFF_CYCLES == 0) ? IRQ_ARB_IDLE : IRQ_ARB_HOLD;
            end else if (!captured_elig) begin
               state_d = IRQ_ARB_IDLE;
            end
         end
         IRQ_ARB_HOLD: begin
            // An NMI abandons the hold-off window entirely.
            if (nm_elig) begin
               sel_d   = '{cause: EXC_CAUSE_IRQ_NM, is_nm: 1'b1};
               cnt_d   = 4'd0;
               state_d = IRQ_ARB_REQ;
            end else if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = IRQ_ARB_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            cnt_d   = 4'd0;
            state_d = IRQ_ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IRQ_ARB_IDLE;
         sel_q        <= '0;
         cnt_q        <= '0;
         sw_q         <= 1'b0;
         tmr_q        <= 1'b0;
         ext_q        <= 1'b0;
         fast_q       <= '0;
         nm_q         <= 1'b0;
         nm_prev_q    <= 1'b0;
         nm_pend_q    <= 1'b0;
         nmi_active_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         sw_q         <= irq_software_i;
         tmr_q        <= irq_timer_i;
         ext_q        <= irq_external_i;
         fast_q       <= irq_fast_i;
         nm_q         <= irq_nm_i;
         nm_prev_q    <= nm_q;
         nm_pend_q    <= (nm_pend_q & ~nm_ack) | nm_edge;
         nmi_active_q <= nm_ack ? 1'b1 : (nmi_active_q & ~nmi_done_i);
      end
   end

   assign irq_req_o    = (state_q == IRQ_ARB_REQ);
   assign irq_cause_o  = sel_q.cause;
   assign irq_is_nm_o  = sel_q.is_nm;
   assign mip_msip_o   = sw_q;
   assign mip_mtip_o   = tmr_q;
   assign mip_meip_o   = ext_q;
   assign mip_fast_o   = fast_ip;
   assign nmi_active_o = nmi_active_q;

endmodule
